// File: rtl/control_loop_cmd_bridge.sv
// rtl/control_loop_cmd_bridge.sv - Wishbone slave that runs control-loop command handshakes for the CPU
//
// Purpose: the CPU loads a 64-bit input word and a command code through
// 32-bit registers, then triggers a transaction. The bridge raises start_cmd,
// waits for finish_cmd (or a timeout), latches word_out, waits for the loop to
// drop finish_cmd, and reports busy/done/timeout/collision status.
//
// Ports:
//   clk, rst_L          - single clock, synchronous active-low reset
//   wb_cyc/stb/we/adr   - Wishbone classic request (3-bit word address)
//   wb_dat_w, wb_dat_r  - write data in, registered read data out
//   wb_ack              - registered single-cycle acknowledge
//   cmd, word_in        - command and data presented to the loop
//   word_out            - data returned by the loop
//   start_cmd           - request to the loop
//   finish_cmd          - completion from the loop

`ifndef CONTROL_LOOP_CMD_WIDTH
`define CONTROL_LOOP_CMD_WIDTH 8
`endif

module control_loop_cmd_bridge #(
  parameter int CMD_WID     = `CONTROL_LOOP_CMD_WIDTH,
  parameter int DATA_WID    = 64,
  parameter int TIMEOUT_WID = 24,
  parameter int TIMEOUT     = 1_000_000
) (
  input  logic                clk,
  input  logic                rst_L,
  input  logic                wb_cyc,
  input  logic                wb_stb,
  input  logic                wb_we,
  input  logic [2:0]          wb_adr,
  input  logic [31:0]         wb_dat_w,
  output logic [31:0]         wb_dat_r,
  output logic                wb_ack,
  output logic [CMD_WID-1:0]  cmd,
  output logic [DATA_WID-1:0] word_in,
  input  logic [DATA_WID-1:0] word_out,
  output logic                start_cmd,
  input  logic                finish_cmd
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_RELEASE = 2'd2
  } state_e;

  localparam logic [2:0] ADR_CTRL    = 3'd0;
  localparam logic [2:0] ADR_WIN_LO  = 3'd1;
  localparam logic [2:0] ADR_WIN_HI  = 3'd2;
  localparam logic [2:0] ADR_WOUT_LO = 3'd3;
  localparam logic [2:0] ADR_WOUT_HI = 3'd4;

  localparam logic [TIMEOUT_WID-1:0] CNT_LAST = TIMEOUT_WID'(TIMEOUT - 1);

  state_e                 state_q, state_d;
  logic [TIMEOUT_WID-1:0] cnt_q, cnt_d;
  logic [CMD_WID-1:0]     cmd_q, cmd_d;
  logic [DATA_WID-1:0]    win_q, win_d;
  logic [DATA_WID-1:0]    wout_q, wout_d;
  logic                   done_q, done_d;
  logic                   timeout_q, timeout_d;
  logic                   coll_q, coll_d;
  logic                   ack_q, ack_d;
  logic [31:0]            dat_r_q, dat_r_d;

  logic        bus_req;
  logic        bus_wr;
  logic        busy;
  logic        start_req;
  logic [63:0] win64;
  logic [63:0] wout64;
  logic [63:0] win_wr_lo;
  logic [63:0] win_wr_hi;
  logic [31:0] rd_data;

  // A request is accepted only while ack is low, so a master that holds
  // cyc/stb through the ack cycle gets exactly one ack per access.
  assign bus_req   = wb_cyc & wb_stb & ~ack_q;
  assign bus_wr    = bus_req & wb_we;
  assign busy      = (state_q != S_IDLE);
  assign start_req = bus_wr && (wb_adr == ADR_CTRL) && !wb_dat_w[31] && !busy;

  // 64-bit views so the halves map cleanly for any DATA_WID up to 64; bits
  // at or above DATA_WID read as zero and are dropped on write.
  assign win64     = 64'(win_q);
  assign wout64    = 64'(wout_q);
  assign win_wr_lo = {win64[63:32], wb_dat_w};
  assign win_wr_hi = {wb_dat_w, win64[31:0]};

  always_comb begin : read_mux
    rd_data = 32'd0;
    case (wb_adr)
      ADR_CTRL:    rd_data = {28'd0, coll_q, timeout_q, done_q, busy};
      ADR_WIN_LO:  rd_data = win64[31:0];
      ADR_WIN_HI:  rd_data = win64[63:32];
      ADR_WOUT_LO: rd_data = wout64[31:0];
      ADR_WOUT_HI: rd_data = wout64[63:32];
      default:     rd_data = 32'd0;
    endcase
  end

  always_comb begin : next_state
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    win_d     = win_q;
    wout_d    = wout_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    coll_d    = coll_q;
    ack_d     = bus_req;
    dat_r_d   = (bus_req && !wb_we) ? rd_data : 32'd0;

    // Register writes. cmd and word_in are frozen while busy; an attempt to
    // change them (or to start again) is acked but only flags a collision.
    if (bus_wr) begin
      case (wb_adr)
        ADR_CTRL: begin
          if (wb_dat_w[31]) begin
            coll_d = 1'b0;
          end else if (busy) begin
            coll_d = 1'b1;
          end else begin
            cmd_d     = wb_dat_w[CMD_WID-1:0];
            done_d    = 1'b0;
            timeout_d = 1'b0;
          end
        end
        ADR_WIN_LO: begin
          if (busy) coll_d = 1'b1;
          else      win_d  = win_wr_lo[DATA_WID-1:0];
        end
        ADR_WIN_HI: begin
          if (busy) coll_d = 1'b1;
          else      win_d  = win_wr_hi[DATA_WID-1:0];
        end
        default: begin
        end
      endcase
    end

    // Handshake sequencing. start_cmd is decoded from S_REQ, so it rises on
    // the start write's ack edge and falls on the edge that leaves S_REQ.
    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          state_d = S_REQ;
          cnt_d   = '0;
        end
      end
      S_REQ: begin
        // Finish is checked first so it wins over a simultaneous expiry.
        if (finish_cmd) begin
          wout_d  = word_out;
          state_d = S_RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_RELEASE;
        end else begin
          cnt_d = cnt_q + TIMEOUT_WID'(1);
        end
      end
      S_RELEASE: begin
        if (!finish_cmd) begin
          state_d = S_IDLE;
          if (!timeout_q) done_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_L) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cmd_q     <= '0;
      win_q     <= '0;
      wout_q    <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      coll_q    <= 1'b0;
      ack_q     <= 1'b0;
      dat_r_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      win_q     <= win_d;
      wout_q    <= wout_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      coll_q    <= coll_d;
      ack_q     <= ack_d;
      dat_r_q   <= dat_r_d;
    end
  end

  assign wb_ack    = ack_q;
  assign wb_dat_r  = dat_r_q;
  assign cmd       = cmd_q;
  assign word_in   = win_q;
  assign start_cmd = (state_q == S_REQ);

endmodule

// File: tb/tb_control_loop_cmd_bridge.sv
// tb/tb_control_loop_cmd_bridge.sv - scoreboard bench for control_loop_cmd_bridge
module tb_control_loop_cmd_bridge;

  localparam int T = 256;

  logic        clk;
  logic        rst_L;
  logic        wb_cyc, wb_stb, wb_we;
  logic [2:0]  wb_adr;
  logic [31:0] wb_dat_w, wb_dat_r;
  logic        wb_ack;
  logic [7:0]  cmd;
  logic [63:0] word_in, word_out;
  logic        start_cmd, finish_cmd;

  control_loop_cmd_bridge #(
    .CMD_WID(8), .DATA_WID(64), .TIMEOUT_WID(24), .TIMEOUT(T)
  ) u_dut (
    .clk(clk), .rst_L(rst_L),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_dat_w(wb_dat_w), .wb_dat_r(wb_dat_r), .wb_ack(wb_ack),
    .cmd(cmd), .word_in(word_in), .word_out(word_out),
    .start_cmd(start_cmd), .finish_cmd(finish_cmd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests;
  int fails;

  // Reference model of the register file / status flags
  logic [63:0] m_win, m_wout;
  logic [7:0]  m_cmd;
  bit          m_busy, m_done, m_to, m_coll;

  // Loop behaviour for the current transaction (-1: never finishes)
  int          loop_delay;
  logic [63:0] loop_word;

  // Scoreboards
  bit          rd_q[$];
  logic [31:0] rdat_q[$];
  string       nm_q[$];
  int          dur_q[$];
  logic [63:0] exp_word_in;
  logic [7:0]  exp_cmd;
  bit          cur_to;
  logic [63:0] cur_word;

  function automatic logic [31:0] status_exp();
    return {28'd0, m_coll, m_to, m_done, m_busy};
  endfunction

  task automatic model_reset();
    m_win = '0; m_wout = '0; m_cmd = '0;
    m_busy = 0; m_done = 0; m_to = 0; m_coll = 0;
  endtask

  task automatic wb_xfer(input bit we, input logic [2:0] adr, input logic [31:0] dat);
    bit got;
    int waited;
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_w = dat;
    got = 0;
    waited = 0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      waited++;
      if (wb_ack === 1'b1) got = 1;
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    tests++;
    if (!got || waited != 1) begin
      fails++;
      $display("FAIL ack_latency adr=%0d: got ack=%0b after %0d clocks, required ack after 1 clock", adr, got, waited);
    end
  endtask

  task automatic do_write(input logic [2:0] adr, input logic [31:0] dat);
    rd_q.push_back(1'b0); rdat_q.push_back(32'd0); nm_q.push_back("write");
    case (adr)
      3'd0: begin
        if (dat[31]) m_coll = 0;
        else if (m_busy) m_coll = 1;
        else begin m_cmd = dat[7:0]; m_done = 0; m_to = 0; m_busy = 1; end
      end
      3'd1: if (m_busy) m_coll = 1; else m_win[31:0] = dat;
      3'd2: if (m_busy) m_coll = 1; else m_win[63:32] = dat;
      default: begin end
    endcase
    wb_xfer(1'b1, adr, dat);
  endtask

  task automatic do_read(input logic [2:0] adr, input logic [31:0] exp, input string name);
    rd_q.push_back(1'b1); rdat_q.push_back(exp); nm_q.push_back(name);
    wb_xfer(1'b0, adr, 32'd0);
  endtask

  // Issues a CTRL start; returns at the negedge right after the ack edge.
  task automatic run_txn(input logic [7:0] c, input int delay, input logic [63:0] w, input int dur);
    loop_delay = delay;
    loop_word  = w;
    exp_word_in = m_win;
    exp_cmd     = c;
    dur_q.push_back(dur);
    cur_to   = (delay < 0 || delay > T);
    cur_word = w;
    do_write(3'd0, {1'b0, 23'($urandom), c});
  endtask

  task automatic finish_txn(input int w);
    repeat (w) @(negedge clk);
    m_busy = 0;
    if (cur_to) m_to = 1;
    else begin m_done = 1; m_wout = cur_word; end
  endtask

  // Bus monitor: pops one expectation per ack and checks read data
  initial begin : bus_mon
    bit          is_rd;
    logic [31:0] e;
    string       n;
    forever begin
      @(negedge clk);
      if (wb_ack === 1'b1) begin
        if (rd_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_ack: got ack with data %h, required no ack", wb_dat_r);
        end else begin
          is_rd = rd_q.pop_front(); e = rdat_q.pop_front(); n = nm_q.pop_front();
          if (is_rd) begin
            tests++;
            if (wb_dat_r !== e) begin
              fails++;
              $display("FAIL %s: got %h, required %h", n, wb_dat_r, e);
            end
          end
        end
      end
    end
  end

  // start_cmd pulse monitor: length and stability of cmd/word_in while high
  initial begin : pulse_mon
    int len, bad, d;
    len = 0; bad = 0;
    forever begin
      @(negedge clk);
      if (start_cmd === 1'b1) begin
        len++;
        if (word_in !== exp_word_in || cmd !== exp_cmd) bad++;
      end else if (len != 0) begin
        tests++;
        if (dur_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_start: got start_cmd pulse of %0d clocks, required none", len);
        end else begin
          d = dur_q.pop_front();
          if (len != d) begin
            fails++;
            $display("FAIL start_len: got %0d clocks, required %0d", len, d);
          end
        end
        tests++;
        if (bad != 0) begin
          fails++;
          $display("FAIL req_stable: got %0d changed clocks of cmd/word_in, required 0", bad);
        end
        len = 0; bad = 0;
      end
    end
  end

  // Control-loop model: finish is sampled on the loop_delay-th edge after
  // start rose and is released one clock after start falls.
  initial begin : loop_model
    int d, k;
    finish_cmd = 1'b0;
    word_out   = '0;
    forever begin
      @(negedge clk);
      if (start_cmd === 1'b1 && finish_cmd == 1'b0) begin
        d = loop_delay;
        word_out = ~loop_word;
        if (d < 0) begin
          while (start_cmd === 1'b1) @(negedge clk);
        end else begin
          k = 1;
          while (k < d && start_cmd === 1'b1) begin
            @(negedge clk);
            k++;
          end
          if (start_cmd === 1'b1) begin
            finish_cmd = 1'b1;
            word_out   = loop_word;
            while (start_cmd === 1'b1) @(negedge clk);
            finish_cmd = 1'b0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t, required completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [63:0] w;
    logic [7:0]  c;
    int          d;
    tests = 0; fails = 0;
    wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_adr = '0; wb_dat_w = '0;
    loop_delay = -1; loop_word = '0;
    exp_word_in = '0; exp_cmd = '0;
    model_reset();
    rst_L = 1'b0;
    repeat (3) @(negedge clk);
    rst_L = 1'b1;

    do_read(3'd0, 32'd0, "rst_status");
    do_read(3'd1, 32'd0, "rst_win_lo");
    do_read(3'd4, 32'd0, "rst_wout_hi");
    do_read(3'd6, 32'd0, "rst_adr6");

    // Read path
    do_write(3'd1, 32'd0);
    do_write(3'd2, 32'd0);
    run_txn(8'h11, 5, 64'h0123_4567_89AB_CDEF, 5);
    finish_txn(9);
    do_read(3'd3, 32'h89AB_CDEF, "rd_wout_lo");
    do_read(3'd4, 32'h0123_4567, "rd_wout_hi");
    do_read(3'd0, 32'h2, "rd_status");

    // Write path, long loop latency
    do_write(3'd2, 32'h0000_0001);
    do_write(3'd1, 32'h8000_0000);
    w = {$urandom, $urandom};
    run_txn(8'h22, 200, w, 200);
    finish_txn(204);
    do_read(3'd0, 32'h2, "wr_status");
    do_read(3'd1, 32'h8000_0000, "wr_win_lo");
    do_read(3'd2, 32'h0000_0001, "wr_win_hi");
    do_read(3'd3, w[31:0], "wr_wout_lo");

    // Timeout: loop never finishes, WOUT keeps the previous result
    run_txn(8'h33, -1, {$urandom, $urandom}, T);
    finish_txn(T + 4);
    do_read(3'd0, 32'h4, "to_status");
    do_read(3'd3, w[31:0], "to_wout_lo");
    do_read(3'd4, w[63:32], "to_wout_hi");

    // Race: finish sampled on the expiry clock
    w = {$urandom, $urandom};
    run_txn(8'h44, T, w, T);
    finish_txn(T + 4);
    do_read(3'd0, 32'h2, "race_status");
    do_read(3'd3, w[31:0], "race_wout_lo");
    do_read(3'd4, w[63:32], "race_wout_hi");

    // Collision during REQ
    run_txn(8'h55, 60, {$urandom, $urandom}, 60);
    do_write(3'd1, 32'hDEAD_BEEF);
    do_write(3'd0, 32'h0000_00AA);
    do_read(3'd0, 32'h9, "coll_status_busy");
    do_read(3'd1, 32'h8000_0000, "coll_win_lo");
    finish_txn(60);
    do_read(3'd0, 32'hA, "coll_status_done");
    do_write(3'd0, 32'h8000_0000);
    do_read(3'd0, 32'h2, "coll_cleared");

    // Reset in the middle of REQ
    run_txn(8'h66, -1, {$urandom, $urandom}, 10);
    repeat (9) @(negedge clk);
    rst_L = 1'b0;
    @(negedge clk);
    rst_L = 1'b1;
    model_reset();
    tests++;
    if (start_cmd !== 1'b0) begin
      fails++;
      $display("FAIL rst_start: got start_cmd=%b, required 0", start_cmd);
    end
    do_read(3'd0, 32'd0, "rstreq_status");
    do_read(3'd3, 32'd0, "rstreq_wout_lo");
    do_read(3'd4, 32'd0, "rstreq_wout_hi");
    do_read(3'd2, 32'd0, "rstreq_win_hi");
    w = {$urandom, $urandom};
    run_txn(8'h77, 7, w, 7);
    finish_txn(11);
    do_read(3'd0, 32'h2, "post_rst_status");
    do_read(3'd3, w[31:0], "post_rst_wout_lo");

    // Randomized transactions against the model
    for (int it = 0; it < 12; it++) begin
      do_write(3'd1, $urandom);
      do_write(3'd2, $urandom);
      c = 8'($urandom);
      w = {$urandom, $urandom};
      d = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(10, 40));
      run_txn(c, d, w, (d < 0) ? T : d);
      if ($urandom_range(0, 1) == 1) do_write(3'd2, $urandom);
      finish_txn(((d < 0) ? T : d) + 4);
      do_read(3'd0, status_exp(), "rnd_status");
      do_read(3'd3, m_wout[31:0], "rnd_wout_lo");
      do_read(3'd4, m_wout[63:32], "rnd_wout_hi");
      do_read(3'd2, m_win[63:32], "rnd_win_hi");
      do_write(3'($urandom_range(3, 7)), $urandom);
      do_read(3'($urandom_range(5, 7)), 32'd0, "rnd_unmapped");
      do_read(3'd1, m_win[31:0], "rnd_win_lo");
      if ($urandom_range(0, 2) == 0) do_write(3'd0, 32'h8000_0000);
    end

    repeat (4) @(negedge clk);
    tests++;
    if (rd_q.size() != 0) begin
      fails++;
      $display("FAIL bus_drain: got %0d unacked accesses, required 0", rd_q.size());
    end
    tests++;
    if (dur_q.size() != 0) begin
      fails++;
      $display("FAIL pulse_drain: got %0d missing start pulses, required 0", dur_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
